// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write controller.
// Optional clear sweep is enabled with the RF_INIT_CLEAR_EN macro.
package rf_ctrl_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned DW_DEF   = 16;
  localparam int unsigned AW_DEF   = 3;
  localparam int unsigned NREGS    = 2 ** AW_DEF;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester-side bus for the write controller: req/gnt handshake plus packed address/data.
interface rf_write_arbiter_if
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned AW   = AW_DEF
);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;

  modport master (output req, output req_addr, output req_data, input gnt);
  modport slave  (input req, input req_addr, input req_data, output gnt);

endinterface

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  localparam int unsigned PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  int unsigned idx;
  logic        found;

  // Scan upward from ptr and grant the first requester found
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (enable && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Single-write-port controller for the RegisterFile: round-robin sharing among
// NREQ requesters, with an optional post-reset clear sweep (RF_INIT_CLEAR_EN).
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input  logic                clk_n,
  input  logic                rst_n,
  rf_write_arbiter_if.slave   bus,
  output logic [AW-1:0]       rf_waddr,
  output logic [DW-1:0]       rf_wdata,
  output logic                rf_we,
  output logic                busy
);

  localparam int unsigned PW      = $clog2(NREQ);
  localparam int unsigned NREGS_L = 2 ** AW;

  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt_w;
  logic            xfer;
  logic            sweep_we;
  logic [AW-1:0]   cnt_q;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

`ifdef RF_INIT_CLEAR_EN
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_d;

  // Sweep state and counter register
  always_ff @(posedge clk_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Step the clear sweep through every register, then hand over to arbitration
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      INIT: begin
        sweep_we = 1'b1;
        if (cnt_q == AW'(NREGS_L - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q == INIT);
`else
  assign busy     = 1'b0;
  assign sweep_we = 1'b0;
  assign cnt_q    = '0;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .enable  (rst_n & ~busy),
    .gnt     (gnt_w),
    .gnt_idx (gnt_idx)
  );

  assign bus.gnt = gnt_w;
  assign xfer    = |(bus.req & gnt_w);

  // Select the granted requester's address and data
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_w[i]) begin
        sel_addr = bus.req_addr[i*AW +: AW];
        sel_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  // Round-robin pointer moves just past the requester that was served
  always_ff @(posedge clk_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (xfer) begin
      if (gnt_idx == PW'(NREQ - 1)) ptr_q <= '0;
      else                          ptr_q <= gnt_idx + 1'b1;
    end
  end

  // Registered write port: sweep writes zeros, a handshake writes the request, else idle
  always_ff @(posedge clk_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (sweep_we) begin
      rf_we    <= 1'b1;
      rf_waddr <= cnt_q;
      rf_wdata <= '0;
    end else if (xfer) begin
      rf_we    <= 1'b1;
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter, works with or without RF_INIT_CLEAR_EN.
module tb_rf_write_arbiter;

  logic        clk_n;
  logic        rst_n;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_we;
  logic        busy;
  logic [15:0] regs [8];
  int          checks;
  int          errors;
  int          tally [4];

  rf_write_arbiter_if #(.NREQ(4), .DW(16), .AW(3)) bus ();

  rf_write_arbiter #(.NREQ(4), .DW(16), .AW(3)) dut (
    .clk_n    (clk_n),
    .rst_n    (rst_n),
    .bus      (bus),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rf_we    (rf_we),
    .busy     (busy)
  );

  initial clk_n = 1'b0;
  always #5 clk_n = ~clk_n;

  // RegisterFile write port model
  always @(posedge clk_n) if (rf_we === 1'b1) regs[rf_waddr] <= rf_wdata;

  task automatic step();
    @(posedge clk_n);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [15:0] d);
    bus.req_addr[i*3 +: 3]  = a;
    bus.req_data[i*16 +: 16] = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4; i++) tally[i] = 0;
    rst_n        = 1'b0;
    bus.req      = 4'b1000;
    bus.req_addr = '0;
    bus.req_data = '0;
    set_req(3, 3'd2, 16'h3333);

    // Reset state
    step();
    step();
    #1;
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_gnt", bus.gnt, 0);
`ifdef RF_INIT_CLEAR_EN
    check("rst_busy", busy, 1);
`else
    check("rst_busy", busy, 0);
`endif

    rst_n = 1'b1;
    #1;
`ifdef RF_INIT_CLEAR_EN
    // Clear sweep: 8 zero writes, no grants while busy
    for (int k = 0; k < 8; k++) begin
      check("sweep_busy", busy, 1);
      check("sweep_gnt", bus.gnt, 0);
      step();
      check("sweep_we", rf_we, 1);
      check("sweep_waddr", rf_waddr, k);
      check("sweep_wdata", rf_wdata, 0);
    end
    step_zero_check: begin
      bus.req = 4'b0000;
      step();
      for (int a = 0; a < 8; a++) check("sweep_regs", regs[a], 0);
      bus.req = 4'b1000;
      #1;
    end
`endif
    // First grant after sweep (or right after release when sweep is absent)
    check("first_busy", busy, 0);
    check("first_gnt", bus.gnt, 4'b1000);
    step();
    bus.req = 4'b0000;
    check("first_we", rf_we, 1);
    check("first_waddr", rf_waddr, 2);
    check("first_wdata", rf_wdata, 16'h3333);

    // Idle: we drops, address/data hold
    step();
    check("idle_we", rf_we, 0);
    check("idle_waddr", rf_waddr, 2);
    check("idle_wdata", rf_wdata, 16'h3333);
    check("idle_reg2", regs[2], 16'h3333);

    // Single write from requester 2 (ptr=0)
    set_req(2, 3'd5, 16'haaaa);
    bus.req = 4'b0100;
    #1;
    check("single_gnt", bus.gnt, 4'b0100);
    step();
    bus.req = 4'b0000;
    check("single_we", rf_we, 1);
    check("single_waddr", rf_waddr, 5);
    check("single_wdata", rf_wdata, 16'haaaa);
    step();
    check("single_reg5", regs[5], 16'haaaa);
    check("single_idle_we", rf_we, 0);

    // Bring ptr back to 0 with a grant to requester 3
    set_req(3, 3'd1, 16'h1234);
    bus.req = 4'b1000;
    #1;
    check("ptr3_gnt", bus.gnt, 4'b1000);
    step();

    // Round-robin with all requesting, 8 cycles
    for (int i = 0; i < 4; i++) set_req(i, 3'(i + 4), 16'(16'h1111 * (i + 1)));
    bus.req = 4'b1111;
    #1;
    for (int j = 0; j < 8; j++) begin
      check("rr_gnt", bus.gnt, 4'b0001 << (j % 4));
      for (int i = 0; i < 4; i++) if (bus.gnt[i] === 1'b1) tally[i]++;
      step();
      check("rr_waddr", rf_waddr, (j % 4) + 4);
    end
    bus.req = 4'b0000;
    for (int i = 0; i < 4; i++) check("rr_tally", tally[i], 2);

    // Move ptr to 1 via requester 0
    set_req(0, 3'd6, 16'h0f0f);
    bus.req = 4'b0001;
    #1;
    check("ptr1_gnt", bus.gnt, 4'b0001);
    step();

    // Same-address collision, ptr=1: requester 1 first, then 0
    set_req(0, 3'd0, 16'h1111);
    set_req(1, 3'd0, 16'h2222);
    bus.req = 4'b0011;
    #1;
    check("coll_gnt1", bus.gnt, 4'b0010);
    step();
    check("coll_wdata1", rf_wdata, 16'h2222);
    bus.req = 4'b0001;
    #1;
    check("coll_gnt0", bus.gnt, 4'b0001);
    step();
    bus.req = 4'b0000;
    check("coll_wdata0", rf_wdata, 16'h1111);
    step();
    check("coll_reg0", regs[0], 16'h1111);

    // Reset mid-sweep and reset after a handshake
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
`ifdef RF_INIT_CLEAR_EN
    for (int k = 0; k < 4; k++) step();
    check("midsweep_waddr", rf_waddr, 3);
    rst_n = 1'b0;
    step();
    check("midsweep_rst_we", rf_we, 0);
    rst_n = 1'b1;
    step();
    check("restart_we", rf_we, 1);
    check("restart_waddr", rf_waddr, 0);
    check("restart_busy", busy, 1);
    for (int k = 0; k < 7; k++) step();
    check("restart_last_waddr", rf_waddr, 7);
    check("restart_done_busy", busy, 0);
`else
    check("nosweep_busy", busy, 0);
`endif
    set_req(1, 3'd7, 16'hbeef);
    bus.req = 4'b0010;
    #1;
    check("hs_gnt", bus.gnt, 4'b0010);
    step();
    check("hs_we", rf_we, 1);
    bus.req = 4'b0000;
    rst_n = 1'b0;
    step();
    check("hs_drop_we", rf_we, 0);
    check("hs_drop_waddr", rf_waddr, 0);
    check("hs_drop_wdata", rf_wdata, 0);
    rst_n = 1'b1;
    #1;
`ifdef RF_INIT_CLEAR_EN
    for (int k = 0; k < 8; k++) step();
`endif
    // ptr must be back at 0
    bus.req = 4'b1111;
    #1;
    check("ptr_rst_gnt", bus.gnt, 4'b0001);
    check("end_busy", busy, 0);
    bus.req = 4'b0000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
